// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit message sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP
    } seq_state_t;

endpackage

// File: rtl/uart_tx_msg_seq_gap_timer.sv
// Load/count-down timer shared by the inter-character gap and the ack timeout.
// Latency: load takes effect on the next edge; zero flag is combinational from the count.
// Backpressure: none; counts down only while dec is held and parks at zero.
module uart_gap_timer #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/uart_tx_msg_seq.sv
// Streams a compile-time character table to a UART byte transmitter on a trigger pulse.
// Latency: trig -> tx_en in 2 cycles; busy fall -> next tx_en in GAP_CYCLES+2 cycles.
// Backpressure: waits on tx_busy rise/fall per byte; UART_TX_MSG_CRLF_EN appends CR LF.
module uart_tx_msg_seq
    import uart_pkg::*;
#(
    parameter int                          DATA_W      = DEF_DATA_W,
    parameter int                          MSG_LEN     = 4,
    parameter logic [MSG_LEN*DATA_W-1:0]   MSG_STR     = {"D", "C", "B", "A"},
    parameter int                          GAP_CYCLES  = 0,
    parameter int                          ACK_TIMEOUT = 16,
    parameter int                          IDX_W       = $clog2(MSG_LEN + 2)
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              loop_mode,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              seq_busy,
    output logic [IDX_W-1:0]  char_idx,
    output logic              done,
    output logic              ack_err
);

`ifdef UART_TX_MSG_CRLF_EN
    localparam int N_CHARS = MSG_LEN + 2;
`else
    localparam int N_CHARS = MSG_LEN;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);
    localparam logic [15:0]      ACK_LD   = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0]      GAP_LD   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    seq_state_t        state, state_nxt;
    logic              loop_r, stop_req;
    logic              accept, gap_exit, msg_done, ack_timeout;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [15:0]       tmr_val;
    logic [DATA_W-1:0] char_sel;

    always_comb begin
        char_sel = '0;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (char_idx == IDX_W'(i)) char_sel = MSG_STR[i*DATA_W +: DATA_W];
        end
`ifdef UART_TX_MSG_CRLF_EN
        if (char_idx == IDX_W'(MSG_LEN))     char_sel = DATA_W'(ASCII_CR);
        if (char_idx == IDX_W'(MSG_LEN + 1)) char_sel = DATA_W'(ASCII_LF);
`endif
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        gap_exit    = 1'b0;
        msg_done    = 1'b0;
        ack_timeout = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        tx_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: begin
                tx_en     = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = ACK_LD;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmr_zero) begin
                    ack_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        gap_exit = 1'b1;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LD;
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) gap_exit = 1'b1;
                else          tmr_dec  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A pending stop ends the run after the current character, even mid-message.
        if (gap_exit) begin
            if (stop_req || ((char_idx == LAST_IDX) && !loop_r)) begin
                msg_done  = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_LOAD;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            char_idx <= '0;
            tx_data  <= '0;
            loop_r   <= 1'b0;
            stop_req <= 1'b0;
            ack_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= msg_done;
            if (accept) begin
                loop_r   <= loop_mode;
                ack_err  <= 1'b0;
                char_idx <= '0;
                stop_req <= 1'b0;
            end else if (trig && loop_r && (state != ST_IDLE) && !gap_exit) begin
                stop_req <= 1'b1;
            end
            if (state == ST_LOAD) tx_data <= char_sel;
            if (ack_timeout)      ack_err <= 1'b1;
            if (gap_exit) begin
                if (msg_done)                  stop_req <= 1'b0;
                else if (char_idx == LAST_IDX) char_idx <= '0;
                else                           char_idx <= char_idx + IDX_W'(1);
            end
        end
    end

    assign seq_busy = (state != ST_IDLE);

    uart_gap_timer #(
        .CNT_W (16)
    ) u_gap_timer (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

endmodule

// File: tb/tb_uart_tx_msg_seq.sv
// Bench for uart_tx_msg_seq: one instance with no gap, one with a 5-cycle gap,
// each driven by a simple transmitter model that raises busy the cycle after tx_en.
`timescale 1ns/1ps
module tb_uart_tx_msg_seq;

    localparam int                   MSG_LEN = 4;
    localparam logic [MSG_LEN*8-1:0] MSG     = {"D", "C", "B", "A"};
    localparam int                   IDX_W   = $clog2(MSG_LEN + 2);
    localparam int                   ACK_TO  = 16;
    localparam int                   GAP1    = 5;
`ifdef UART_TX_MSG_CRLF_EN
    localparam int N_CH = MSG_LEN + 2;
`else
    localparam int N_CH = MSG_LEN;
`endif

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             trig      [2];
    logic             loop_mode [2];
    logic             tx_busy   [2];
    logic             tx_en     [2];
    logic [7:0]       tx_data   [2];
    logic             seq_busy  [2];
    logic [IDX_W-1:0] char_idx  [2];
    logic             done      [2];
    logic             ack_err   [2];

    int total = 0;
    int bad   = 0;

    // transmitter model controls and monitor records
    int         busy_len [2] = '{4, 4};
    bit         busy_dis [2] = '{1'b0, 1'b0};
    bit         en_seen  [2] = '{1'b0, 1'b0};
    int         rem      [2] = '{0, 0};
    int         cyc          = 0;
    int         en_n     [2] = '{0, 0};
    logic [7:0] en_dat   [2][256];
    int         en_cyc   [2][256];
    int         fall_n   [2] = '{0, 0};
    int         fall_cyc [2][256];
    int         done_n   [2] = '{0, 0};
    int         data_chg [2] = '{0, 0};
    int         ack_rise [2] = '{0, 0};
    logic       busy_prev[2] = '{1'b0, 1'b0};
    logic       ack_prev [2] = '{1'b0, 1'b0};
    logic [7:0] held     [2] = '{8'h00, 8'h00};

    uart_tx_msg_seq #(
        .DATA_W(8), .MSG_LEN(MSG_LEN), .MSG_STR(MSG), .GAP_CYCLES(0), .ACK_TIMEOUT(ACK_TO)
    ) u_dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .trig(trig[0]), .loop_mode(loop_mode[0]),
        .tx_busy(tx_busy[0]), .tx_en(tx_en[0]), .tx_data(tx_data[0]), .seq_busy(seq_busy[0]),
        .char_idx(char_idx[0]), .done(done[0]), .ack_err(ack_err[0])
    );

    uart_tx_msg_seq #(
        .DATA_W(8), .MSG_LEN(MSG_LEN), .MSG_STR(MSG), .GAP_CYCLES(GAP1), .ACK_TIMEOUT(ACK_TO)
    ) u_dut5 (
        .sys_clk(sys_clk), .rst_n(rst_n), .trig(trig[1]), .loop_mode(loop_mode[1]),
        .tx_busy(tx_busy[1]), .tx_en(tx_en[1]), .tx_data(tx_data[1]), .seq_busy(seq_busy[1]),
        .char_idx(char_idx[1]), .done(done[1]), .ack_err(ack_err[1])
    );

    always #5 sys_clk = ~sys_clk;

    // Byte k of the transmitted stream, wrapping for loop mode.
    function automatic logic [7:0] exp_byte(input int k);
        int                   i;
        logic [MSG_LEN*8-1:0] m;
        i = k % N_CH;
        m = MSG;
        if (i < MSG_LEN) return m[i*8 +: 8];
        if (i == MSG_LEN) return 8'h0D;
        return 8'h0A;
    endfunction

    // Transmitter: busy high for busy_len full cycles, starting the cycle after tx_en.
    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (en_seen[d])      rem[d] = busy_len[d];
            else if (rem[d] > 0) rem[d] = rem[d] - 1;
            tx_busy[d] = (rem[d] > 0);
        end
    end

    always @(negedge sys_clk) begin
        for (int d = 0; d < 2; d++) begin
            en_seen[d] = (tx_en[d] === 1'b1) && !busy_dis[d];
            if (tx_en[d] === 1'b1) begin
                if (en_n[d] < 256) begin
                    en_dat[d][en_n[d]] = tx_data[d];
                    en_cyc[d][en_n[d]] = cyc;
                end
                en_n[d] = en_n[d] + 1;
                held[d] = tx_data[d];
            end
            if (done[d] === 1'b1) done_n[d] = done_n[d] + 1;
            if (busy_prev[d] === 1'b1 && tx_busy[d] === 1'b0) begin
                if (fall_n[d] < 256) fall_cyc[d][fall_n[d]] = cyc;
                fall_n[d] = fall_n[d] + 1;
            end
            if (tx_busy[d] === 1'b1 && tx_data[d] !== held[d]) data_chg[d] = data_chg[d] + 1;
            if (ack_err[d] === 1'b1 && ack_prev[d] !== 1'b1) ack_rise[d] = cyc;
            busy_prev[d] = tx_busy[d];
            ack_prev[d]  = ack_err[d];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (tx_en[d] !== 1'b0)    begin bad++; $display("FAIL reset_tx_en[%0d]: got %b want 0", d, tx_en[d]); end
            total++; if (tx_data[d] !== 8'h00) begin bad++; $display("FAIL reset_tx_data[%0d]: got %h want 00", d, tx_data[d]); end
            total++; if (seq_busy[d] !== 1'b0) begin bad++; $display("FAIL reset_seq_busy[%0d]: got %b want 0", d, seq_busy[d]); end
            total++; if (char_idx[d] !== '0)   begin bad++; $display("FAIL reset_char_idx[%0d]: got %0d want 0", d, char_idx[d]); end
            total++; if (done[d] !== 1'b0)     begin bad++; $display("FAIL reset_done[%0d]: got %b want 0", d, done[d]); end
            total++; if (ack_err[d] !== 1'b0)  begin bad++; $display("FAIL reset_ack_err[%0d]: got %b want 0", d, ack_err[d]); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_single_shot();
        int h, b, bd, bc;
        h  = $urandom_range(1, 12);
        busy_len[0]  = h;
        b  = en_n[0]; bd = done_n[0]; bc = data_chg[0];
        loop_mode[0] = 1'b0;
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        for (int i = 0; i < 3000 && seq_busy[0] === 1'b1; i++) @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
        total++; if (seq_busy[0] !== 1'b0) begin bad++; $display("FAIL single_idle: seq_busy=%b want 0", seq_busy[0]); end
        total++; if (en_n[0] - b != N_CH) begin bad++; $display("FAIL single_count: tx_en=%0d want %0d", en_n[0] - b, N_CH); end
        for (int k = 0; k < N_CH; k++) begin
            total++;
            if (en_dat[0][b+k] !== exp_byte(k)) begin
                bad++; $display("FAIL single_data[%0d]: got %h want %h", k, en_dat[0][b+k], exp_byte(k));
            end
            if (k > 0) begin
                total++;
                if (en_cyc[0][b+k] - en_cyc[0][b+k-1] != h + 3) begin
                    bad++; $display("FAIL single_spacing[%0d]: got %0d want %0d", k, en_cyc[0][b+k] - en_cyc[0][b+k-1], h + 3);
                end
            end
        end
        total++; if (done_n[0] - bd != 1) begin bad++; $display("FAIL single_done: pulses=%0d want 1", done_n[0] - bd); end
        total++; if (data_chg[0] != bc) begin bad++; $display("FAIL single_data_stable: changes=%0d want 0", data_chg[0] - bc); end
        total++; if (char_idx[0] !== IDX_W'(N_CH - 1)) begin bad++; $display("FAIL single_char_idx: got %0d want %0d", char_idx[0], N_CH - 1); end
    endtask

    task automatic test_loop();
        int h, b, bd, k_stop;
        h      = $urandom_range(2, 8);
        k_stop = $urandom_range(N_CH + 1, 2 * N_CH - 1);
        busy_len[0] = h;
        b = en_n[0]; bd = done_n[0];
        loop_mode[0] = 1'b1;
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        loop_mode[0] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5000 && (en_n[0] - b) < k_stop; i++) @(negedge sys_clk);
        for (int i = 0; i < 50 && tx_busy[0] !== 1'b1; i++) @(negedge sys_clk);
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        for (int i = 0; i < 3000 && seq_busy[0] === 1'b1; i++) @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
        total++; if (seq_busy[0] !== 1'b0) begin bad++; $display("FAIL loop_idle: seq_busy=%b want 0", seq_busy[0]); end
        total++; if (en_n[0] - b != k_stop) begin bad++; $display("FAIL loop_count: tx_en=%0d want %0d", en_n[0] - b, k_stop); end
        for (int k = 0; k < k_stop; k++) begin
            total++;
            if (en_dat[0][b+k] !== exp_byte(k)) begin
                bad++; $display("FAIL loop_data[%0d]: got %h want %h", k, en_dat[0][b+k], exp_byte(k));
            end
        end
        total++; if (done_n[0] - bd != 1) begin bad++; $display("FAIL loop_done: pulses=%0d want 1", done_n[0] - bd); end
        total++; if (char_idx[0] !== IDX_W'((k_stop - 1) % N_CH)) begin bad++; $display("FAIL loop_char_idx: got %0d want %0d", char_idx[0], (k_stop - 1) % N_CH); end
    endtask

    task automatic test_timeout();
        int b, bd;
        b = en_n[0]; bd = done_n[0];
        busy_dis[0]  = 1'b1;
        loop_mode[0] = 1'b0;
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        for (int i = 0; i < 80 && ack_err[0] !== 1'b1; i++) @(negedge sys_clk);
        @(negedge sys_clk);
        total++; if (ack_err[0] !== 1'b1) begin bad++; $display("FAIL timeout_ack_err: got %b want 1", ack_err[0]); end
        total++; if (ack_rise[0] - en_cyc[0][b] != ACK_TO + 1) begin bad++; $display("FAIL timeout_delay: got %0d want %0d", ack_rise[0] - en_cyc[0][b], ACK_TO + 1); end
        total++; if (en_n[0] - b != 1) begin bad++; $display("FAIL timeout_count: tx_en=%0d want 1", en_n[0] - b); end
        total++; if (seq_busy[0] !== 1'b0) begin bad++; $display("FAIL timeout_idle: seq_busy=%b want 0", seq_busy[0]); end
        total++; if (done_n[0] != bd) begin bad++; $display("FAIL timeout_no_done: pulses=%0d want 0", done_n[0] - bd); end
        busy_dis[0] = 1'b0;
        busy_len[0] = $urandom_range(1, 6);
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        total++; if (ack_err[0] !== 1'b0) begin bad++; $display("FAIL timeout_clear: ack_err=%b want 0", ack_err[0]); end
        for (int i = 0; i < 3000 && seq_busy[0] === 1'b1; i++) @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
        total++; if (done_n[0] - bd != 1) begin bad++; $display("FAIL timeout_recover_done: pulses=%0d want 1", done_n[0] - bd); end
        total++; if (en_n[0] - b != N_CH + 1) begin bad++; $display("FAIL timeout_recover_count: tx_en=%0d want %0d", en_n[0] - b, N_CH + 1); end
    endtask

    task automatic test_gap();
        int h, b, fb, bd;
        h = $urandom_range(1, 10);
        busy_len[1] = h;
        b = en_n[1]; fb = fall_n[1]; bd = done_n[1];
        loop_mode[1] = 1'b0;
        trig[1] = 1'b1; @(negedge sys_clk); trig[1] = 1'b0;
        for (int i = 0; i < 50 && tx_busy[1] !== 1'b1; i++) @(negedge sys_clk);
        trig[1] = 1'b1; @(negedge sys_clk); trig[1] = 1'b0;
        for (int i = 0; i < 3000 && seq_busy[1] === 1'b1; i++) @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
        total++; if (seq_busy[1] !== 1'b0) begin bad++; $display("FAIL gap_idle: seq_busy=%b want 0", seq_busy[1]); end
        total++; if (en_n[1] - b != N_CH) begin bad++; $display("FAIL gap_count: tx_en=%0d want %0d", en_n[1] - b, N_CH); end
        total++; if (done_n[1] - bd != 1) begin bad++; $display("FAIL gap_done: pulses=%0d want 1", done_n[1] - bd); end
        for (int k = 1; k < N_CH; k++) begin
            total++;
            if (en_cyc[1][b+k] - fall_cyc[1][fb+k-1] != GAP1 + 2) begin
                bad++; $display("FAIL gap_delay[%0d]: got %0d want %0d", k, en_cyc[1][b+k] - fall_cyc[1][fb+k-1], GAP1 + 2);
            end
            total++;
            if (en_dat[1][b+k] !== exp_byte(k)) begin
                bad++; $display("FAIL gap_data[%0d]: got %h want %h", k, en_dat[1][b+k], exp_byte(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        busy_len[0] = $urandom_range(4, 10);
        b = en_n[0];
        loop_mode[0] = 1'b0;
        trig[0] = 1'b1; @(negedge sys_clk); trig[0] = 1'b0;
        for (int i = 0; i < 500 && (en_n[0] - b) < 2; i++) @(negedge sys_clk);
        for (int i = 0; i < 50 && tx_busy[0] !== 1'b1; i++) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_en[0] !== 1'b0)    begin bad++; $display("FAIL rstmid_tx_en: got %b want 0", tx_en[0]); end
        total++; if (tx_data[0] !== 8'h00) begin bad++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data[0]); end
        total++; if (seq_busy[0] !== 1'b0) begin bad++; $display("FAIL rstmid_seq_busy: got %b want 0", seq_busy[0]); end
        total++; if (char_idx[0] !== '0)   begin bad++; $display("FAIL rstmid_char_idx: got %0d want 0", char_idx[0]); end
        total++; if (done[0] !== 1'b0)     begin bad++; $display("FAIL rstmid_done: got %b want 0", done[0]); end
        total++; if (ack_err[0] !== 1'b0)  begin bad++; $display("FAIL rstmid_ack_err: got %b want 0", ack_err[0]); end
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        total++; if (en_n[0] - b != 2) begin bad++; $display("FAIL rstmid_no_tx_en: tx_en=%0d want 2", en_n[0] - b); end
        total++; if (seq_busy[0] !== 1'b0) begin bad++; $display("FAIL rstmid_idle: seq_busy=%b want 0", seq_busy[0]); end
    endtask

    initial begin
        rst_n        = 1'b0;
        trig[0]      = 1'b0; trig[1]      = 1'b0;
        loop_mode[0] = 1'b0; loop_mode[1] = 1'b0;
        test_reset();
        repeat (3) test_single_shot();
        test_loop();
        test_loop();
        test_timeout();
        test_gap();
        test_reset_mid();
        test_single_shot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
